uart_tx_arbiter: RTL

- Shares a single uart_tx serializer between N_REQ byte-stream requesters.
- Round-robin arbitration with packet lock, so multi-byte messages never interleave.
- Registers and holds the data byte for the whole frame. This is required because uart_tx samples wdata at every bit boundary.
- Sits between the UART clients (debug printer, status reporter, etc.) and the uart_tx instance. Watches uart_tx ready to sequence frames.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one uart_tx between N_REQ byte streams
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_wrreq,
    output logic [7:0]         uart_wdata,
    input  logic               uart_ready,
    output logic               busy,
    output logic               err_timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic            lock;
    logic            last_q;
    logic [CW-1:0]   tmo_cnt;

    logic            cand_found;
    logic [IW-1:0]   cand_idx;
    logic [IW-1:0]   scan_idx;
    logic [N_REQ-1:0] cand_onehot;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = rr_ptr;
        scan_idx   = rr_ptr;
        if (lock) begin
            cand_found = req_valid[owner];
            cand_idx   = owner;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                scan_idx = wrap_add(rr_ptr, k);
                if (req_valid[scan_idx]) begin
                    cand_found = 1'b1;
                    cand_idx   = scan_idx;
                end
            end
        end
    end

    assign cand_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << cand_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            req_ack     <= '0;
            uart_wrreq  <= 1'b0;
            uart_wdata  <= 8'h00;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            rr_ptr      <= '0;
            owner       <= '0;
            lock        <= 1'b0;
            last_q      <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            uart_wrreq <= 1'b0;
            req_ack    <= '0;
            case (state)
                S_IDLE: begin
                    if (uart_ready && cand_found) begin
                        uart_wdata <= req_data[{cand_idx, 3'b000} +: 8];
                        uart_wrreq <= 1'b1;
                        req_ack    <= cand_onehot;
                        grant      <= cand_onehot;
                        owner      <= cand_idx;
                        last_q     <= req_last[cand_idx];
                        lock       <= 1'b1;
                        tmo_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!uart_ready) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_HIGH;
                    end else if (tmo_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        // uart_tx never accepted the byte: drop ownership so others are not starved.
                        err_timeout <= 1'b1;
                        lock        <= 1'b0;
                        grant       <= '0;
                        rr_ptr      <= wrap_add(owner, 1);
                        tmo_cnt     <= '0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (uart_ready) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (last_q) begin
                            lock   <= 1'b0;
                            grant  <= '0;
                            rr_ptr <= wrap_add(owner, 1);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
